// File: rtl/data_mem_pkg.sv
// Shared constants and types for the KGP-RISC data memory (data_mem).
package data_mem_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEPTH      = 2 ** DEF_ADDR_W;

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/data_mem_array.sv
// Storage array for data_mem: synchronous write, registered write-first read.
// Writes are gated by the active-low reset level.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter string       INIT_FILE = ""
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [Depth];
    logic [DATA_W-1:0] r_dout;

    // Elaboration-time contents; reset never touches the array.
    initial begin
        for (int unsigned i = 0; i < Depth; i++) begin
            r_mem[i] = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_we) begin
            r_mem[i_addr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout <= '0;
        end else if (i_we) begin
            r_dout <= i_din;
        end else begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/data_mem.sv
// Single-port 1024x32 data memory, registered write-first read, async active-low reset.
// Define DATA_MEM_OUTREG_EN to add a second output register (read latency 2).
module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter string       INIT_FILE = ""
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic [0:0]        wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta
);

    logic [DATA_W-1:0] w_arr_dout;

    data_mem_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .i_clk  (clka),
        .i_rst_n(rsta),
        .i_we   (wea[0]),
        .i_addr (addra),
        .i_din  (dina),
        .o_dout (w_arr_dout)
    );

`ifdef DATA_MEM_OUTREG_EN
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_arr_dout;
        end
    end

    assign douta = r_dout;
`else
    assign douta = w_arr_dout;
`endif

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem using a reference memory model and an expected-data queue.
module tb_data_mem;
    import data_mem_pkg::*;

`ifdef DATA_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clka = 1'b0;
    logic       rsta;
    logic [0:0] wea;
    addr_t      addra;
    word_t      dina;
    word_t      douta;

    word_t model [DEPTH];
    word_t sb [$];
    int    n_checks = 0;
    int    n_errors = 0;

    data_mem u_dut (
        .clka (clka),
        .rsta (rsta),
        .wea  (wea),
        .addra(addra),
        .dina (dina),
        .douta(douta)
    );

    always #5 clka = ~clka;

    // Expected output of the first stage after reset; later stages drain into douta.
    task automatic sb_restart();
        sb.delete();
        for (int i = 1; i < LAT; i++) sb.push_back('0);
    endtask

    // Drive one access, push its expected result and pop whatever douta should now show.
    task automatic step(input logic we, input addr_t addr, input word_t din,
                        output logic vld, output word_t got, output word_t exp);
        @(negedge clka);
        wea   = we;
        addra = addr;
        dina  = din;
        sb.push_back(we ? din : model[addr]);
        if (we) model[addr] = din;
        @(posedge clka);
        #1;
        vld = 1'b0;
        got = douta;
        exp = '0;
        if (sb.size() >= LAT) begin
            vld = 1'b1;
            exp = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        logic vld;
        word_t got, exp;
        rsta = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        #1;
        n_checks++;
        if (douta !== '0) begin
            n_errors++;
            $display("FAIL reset_async: douta=%h required %h", douta, 32'h0);
        end
        repeat (3) @(posedge clka);
        #1;
        n_checks++;
        if (douta !== '0) begin
            n_errors++;
            $display("FAIL reset_hold: douta=%h required %h", douta, 32'h0);
        end
        @(negedge clka);
        rsta = 1'b1;
        sb_restart();
        for (int i = 0; i < LAT; i++) begin
            step(1'b0, addr_t'(1), '0, vld, got, exp);
            if (vld) begin
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL reset_read1: douta=%h required %h", got, exp);
                end
            end
        end
    endtask

    task automatic test_write_read();
        logic  tw [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        addr_t ta [6] = '{addr_t'(2), addr_t'(4), addr_t'(2), addr_t'(2), addr_t'(7), addr_t'(4)};
        word_t td [6] = '{32'd5, 32'd0, 32'd0, 32'd0, 32'h1234_5678, 32'd0};
        logic vld;
        word_t got, exp;
        for (int i = 0; i < 6; i++) begin
            step(tw[i], ta[i], td[i], vld, got, exp);
            if (vld) begin
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL write_read[%0d]: douta=%h required %h", i, got, exp);
                end
            end
        end
    endtask

    task automatic test_boundary();
        logic  tw [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        addr_t ta [5] = '{addr_t'(1023), addr_t'(0), addr_t'(1023), addr_t'(0), addr_t'(0)};
        word_t td [5] = '{32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 32'd0};
        logic vld;
        word_t got, exp;
        for (int i = 0; i < 5; i++) begin
            step(tw[i], ta[i], td[i], vld, got, exp);
            if (vld) begin
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL boundary[%0d]: douta=%h required %h", i, got, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic vld;
        word_t got, exp;
        for (int i = 0; i < 5; i++) begin
            // Two writes to address 3, then reads of it.
            step(i < 2, addr_t'(3), word_t'(i + 1), vld, got, exp);
            if (vld) begin
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL back_to_back[%0d]: douta=%h required %h", i, got, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic vld;
        word_t got, exp;
        for (int i = 0; i < LAT + 1; i++) begin
            step(1'b1, addr_t'(9), 32'h0000_0077, vld, got, exp);
            if (vld) begin
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL pre_reset[%0d]: douta=%h required %h", i, got, exp);
                end
            end
        end
        @(negedge clka);
        #2;
        rsta = 1'b0;
        #1;
        n_checks++;
        if (douta !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_async: douta=%h required %h", douta, 32'h0);
        end
        // Write attempt while held in reset must be ignored.
        @(negedge clka);
        wea = 1'b1; addra = addr_t'(2); dina = 32'h0000_0099;
        @(posedge clka);
        #1;
        n_checks++;
        if (douta !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_hold: douta=%h required %h", douta, 32'h0);
        end
        @(negedge clka);
        wea = 1'b0;
        rsta = 1'b1;
        sb_restart();
        for (int i = 0; i < LAT + 1; i++) begin
            step(1'b0, addr_t'(2), '0, vld, got, exp);
            if (vld) begin
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL reset_mid_keep[%0d]: douta=%h required %h", i, got, exp);
                end
            end
        end
    endtask

    task automatic test_read_latency();
        addr_t ta [4] = '{addr_t'(4), addr_t'(2), addr_t'(4), addr_t'(1023)};
        logic vld;
        word_t got, exp;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, ta[i], '0, vld, got, exp);
            if (vld) begin
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL read_latency[%0d]: douta=%h required %h", i, got, exp);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        test_reset();
        test_write_read();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_read_latency();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
